display_arbiter: RTL
====================

Name: display_arbiter

Overview:
- Shares the single display output driver between NUM_REQ independent requesters, e.g. 0 = error/status, 1 = ALU result, 2 = operand entry echo.
- Each requester slot holds only its latest value; older pending values are overwritten.
- Issues one transfer at a time using fixed priority, and waits for the driver's shift-out to complete before issuing again.
- Periodically re-sends the last shown value so the display stays refreshed.

Parameters:
- DATA_WIDTH, 16, width of each display value.
- NUM_REQ, 3, number of requesters; index 0 has the highest priority.
- REFRESH_CYCLES, 1000000, idle cycles before the last value is re-sent; 0 disables refresh.
- SRC_W, $clog2(NUM_REQ) (minimum 1), width of the source index.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_data  in  NUM_REQ*DATA_WIDTH  per-requester value; slot k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- req_2s_comp  in  NUM_REQ  per-requester two's-complement flag.
- req_valid  in  NUM_REQ  per-requester valid.
- req_ready  out  NUM_REQ  per-requester ready.
- o_data  out  DATA_WIDTH  value sent to the driver.
- o_2s_comp  out  1  flag sent to the driver.
- o_valid  out  1  valid to the driver.
- i_ready  in  1  ready from the driver.
- i_done  in  1  driver done; low while shifting.
- o_active_src  out  SRC_W  source index of the most recently granted requester.
- o_busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; pending=0; all slot registers=0; shown_valid=0; refresh counter=0.
  - o_valid=0, o_data=0, o_2s_comp=0, o_active_src=0.
  - Reset mid-transfer abandons the transfer and all pending values; after reset the block returns to IDLE.
- Requester side:
  - req_ready[k] = !rst, so requests are always accepted.
  - req_valid[k]&req_ready[k] loads slot k (data + flag) and sets pending[k]; a newer accept overwrites an unissued value.
- States:
  - IDLE:
    - If any pending bit is set, grant the lowest pending index g. Load o_data/o_2s_comp from slot g, clear pending[g], set o_active_src=g, set shown_valid=1, clear the refresh counter, set o_valid=1 → ISSUE.
    - Else, if REFRESH_CYCLES≠0, shown_valid=1 and counter==REFRESH_CYCLES-1: clear the counter, set o_valid=1 with o_data/o_2s_comp/o_active_src unchanged → ISSUE.
    - Else the counter increments, saturating at REFRESH_CYCLES-1.
  - ISSUE:
    - o_valid=1 with o_data and o_2s_comp held stable until i_ready=1.
    - On the handshake cycle: o_valid=0 next cycle → WAIT_START.
  - WAIT_START:
    - Wait for i_done=0 → WAIT_DONE.
    - The driver contract is that i_done is low no later than the cycle after the handshake.
  - WAIT_DONE:
    - Wait for i_done=1 → IDLE.
    - The earliest next grant is the cycle after returning to IDLE.
- Counter behaviour: the refresh counter counts only in IDLE with no pending bits set. It is held in every other state and cleared on any grant or refresh issue.
- Simultaneous events:
  - An accept on slot g in the same cycle as g's grant: the grant uses the old slot contents, the new value is loaded, and pending[g] stays set. It is issued as a new transfer after the current one completes.
  - A requester that becomes pending during a refresh waits for that refresh to finish.
  - Several pending bits at once: the lowest index wins. Higher indices wait, and a continuously re-requesting slot 0 can starve the others; this is accepted.
- Transfer ordering: never more than one transfer in flight; o_valid is never asserted outside ISSUE.
- Before any grant since reset: no refresh is issued and the display driver stays untouched.

Test Plan:
- Reset, then pulse req_valid[1] for one cycle with req_data[1]=0x1234, req_2s_comp[1]=0, i_ready=1 → next cycle o_valid=1, o_data=0x1234, o_active_src=1. After the handshake, o_valid=0 and o_busy stays 1 until the bench raises i_done.
- Hold i_ready=0 for 5 cycles while ISSUE is active with o_data=0x00FF → o_valid and o_data stay stable for all 5 cycles; the handshake completes on the first cycle with i_ready=1.
- Pulse req 2 (0x0007) and req 0 (0xEEEE, 2s_comp=1) in the same cycle → o_data=0xEEEE/o_active_src=0 is issued first; after the done cycle, 0x0007/o_active_src=2 is issued.
- Pulse slot 1 with 0x0001, then 0x0002, while a slot-0 transfer is in WAIT_DONE → only 0x0002 is issued for slot 1.
- REFRESH_CYCLES=8, one transfer of 0x4321 completed, no further requests → o_valid re-asserts with 0x4321 after 8 idle cycles, then every 8 idle cycles plus the transfer time. With no grant since reset, o_valid never asserts.
- Assert rst during WAIT_DONE → next cycle o_valid=0, o_busy=0, pending cleared. A pending slot-2 value recorded before the reset is never issued.

Source files
------------

// File: rtl/display_arbiter.sv
// Shares one display driver among NUM_REQ requesters; latest-value slots, fixed priority, periodic refresh.
// Latency: accept at edge N, grant (o_valid high) from edge N+1 when IDLE; one transfer in flight at a time.
// Backpressure: requesters are never stalled (slots overwrite); o_valid/o_data hold until i_ready, then wait on i_done.
module display_arbiter #(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_REQ        = 3,
    parameter int REFRESH_CYCLES = 1000000,
    parameter int SRC_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_2s_comp,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic                          o_2s_comp,
    output logic                          o_valid,
    input  logic                          i_ready,
    input  logic                          i_done,
    output logic [SRC_W-1:0]              o_active_src,
    output logic                          o_busy
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] ISSUE      = 2'd1;
    localparam logic [1:0] WAIT_START = 2'd2;
    localparam logic [1:0] WAIT_DONE  = 2'd3;

    // Counter only needs to reach REFRESH_CYCLES-1, where it saturates.
    localparam int              CNT_W      = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);
    localparam logic            REFRESH_EN = (REFRESH_CYCLES != 0);

    logic [1:0]                           state;
    logic [NUM_REQ-1:0]                   pending;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   slot_data;
    logic [NUM_REQ-1:0]                   slot_flag;
    logic                                 shown_valid;
    logic [CNT_W-1:0]                     cnt;

    logic [NUM_REQ-1:0]                   accept;
    logic [NUM_REQ-1:0]                   gnt_mask;
    logic [SRC_W-1:0]                     gnt_idx;
    logic [NUM_REQ-1:0]                   pending_clr;
    logic                                 any_pending;
    logic                                 refresh_due;

    assign req_ready   = {NUM_REQ{~rst}};
    assign accept      = req_valid & req_ready;
    assign any_pending = |pending;
    assign o_busy      = (state != IDLE);
    assign refresh_due = REFRESH_EN && shown_valid && (cnt == CNT_MAX);
    // A grant consumes the pending bit, but a same-cycle accept re-arms it below.
    assign pending_clr = (state == IDLE) ? gnt_mask : '0;

    // Fixed priority: lowest pending index wins.
    always_comb begin
        gnt_idx  = '0;
        gnt_mask = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (pending[k]) begin
                gnt_idx  = SRC_W'(k);
                gnt_mask = NUM_REQ'(1) << k;
            end
        end
    end

    // Requester slots: latest accepted value per requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_data <= '0;
            slot_flag <= '0;
            pending   <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (accept[k]) begin
                    slot_data[k] <= req_data[k*DATA_WIDTH +: DATA_WIDTH];
                    slot_flag[k] <= req_2s_comp[k];
                end
            end
            pending <= (pending & ~pending_clr) | accept;
        end
    end

    // Transfer FSM with driver handshake, done tracking and refresh timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            shown_valid  <= 1'b0;
            cnt          <= '0;
            o_valid      <= 1'b0;
            o_data       <= '0;
            o_2s_comp    <= 1'b0;
            o_active_src <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_pending) begin
                        o_data       <= slot_data[gnt_idx];
                        o_2s_comp    <= slot_flag[gnt_idx];
                        o_active_src <= gnt_idx;
                        shown_valid  <= 1'b1;
                        cnt          <= '0;
                        o_valid      <= 1'b1;
                        state        <= ISSUE;
                    end else if (refresh_due) begin
                        // Re-send the value already held on o_data/o_2s_comp.
                        cnt     <= '0;
                        o_valid <= 1'b1;
                        state   <= ISSUE;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ISSUE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= WAIT_START;
                    end
                end
                WAIT_START: begin
                    if (!i_done) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (i_done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
